// File: rtl/internal_regfile.sv
// 32 x 8-bit register file holding the I3C HDR command descriptor (bytes 1..8).
// Define INTERNAL_REGF_WR_BYPASS_EN for write-first reads on same-address read/write.
module internal_regfile (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [4:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       i_engine_Dummy_conf,
  output logic [2:0] o_cccnt_CMD_ATTR,
  output logic [3:0] o_engine_TID,
  output logic [7:0] o_ccc_CMD,
  output logic       o_engine_CP,
  output logic [4:0] o_cccnt_DEV_INDEX,
  output logic [2:0] o_frmcnt_DTT,
  output logic [2:0] o_engine_MODE,
  output logic       o_cccnt_RnW,
  output logic       o_cccnt_WROC,
  output logic       o_cccnt_TOC,
  output logic       o_cccnt_DBP,
  output logic       o_cccnt_SRE,
  output logic [15:0] o_frmcnt_data_len
);

  localparam int unsigned Depth = 32;
  localparam int unsigned Width = 8;

  logic [Width-1:0] regs_q [Depth];
  logic [Width-1:0] data_out_q, data_out_d;

  logic [2:0]  cmd_attr_q, cmd_attr_d;
  logic [3:0]  tid_q, tid_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        cp_q, cp_d;
  logic [4:0]  dev_index_q, dev_index_d;
  logic [2:0]  dtt_q, dtt_d;
  logic [2:0]  mode_q, mode_d;
  logic        rnw_q, rnw_d;
  logic        wroc_q, wroc_d;
  logic        toc_q, toc_d;
  logic        dbp_q, dbp_d;
  logic        sre_q, sre_d;
  logic [15:0] data_len_q, data_len_d;

  // Read path: read-first by default, optional write-first bypass
  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
`ifdef INTERNAL_REGF_WR_BYPASS_EN
      data_out_d = wr_en ? data_in : regs_q[addr];
`else
      data_out_d = regs_q[addr];
`endif
    end
  end

  // Descriptor decode from current (pre-write) register contents
  always_comb begin
    cmd_attr_d  = cmd_attr_q;
    tid_d       = tid_q;
    cmd_d       = cmd_q;
    cp_d        = cp_q;
    dev_index_d = dev_index_q;
    dtt_d       = dtt_q;
    mode_d      = mode_q;
    rnw_d       = rnw_q;
    wroc_d      = wroc_q;
    toc_d       = toc_q;
    dbp_d       = dbp_q;
    sre_d       = sre_q;
    data_len_d  = data_len_q;
    if (i_engine_Dummy_conf) begin
      cmd_attr_d  = regs_q[1][2:0];
      tid_d       = regs_q[1][6:3];
      cmd_d       = {regs_q[2][6:0], regs_q[1][7]};
      cp_d        = regs_q[2][7];
      dev_index_d = regs_q[3][4:0];
      dtt_d       = {regs_q[4][1:0], regs_q[3][7]};
      mode_d      = regs_q[4][4:2];
      rnw_d       = regs_q[4][5];
      wroc_d      = regs_q[4][6];
      toc_d       = regs_q[4][7];
      dbp_d       = regs_q[5][0];
      sre_d       = regs_q[5][1];
      data_len_d  = {regs_q[8], regs_q[7]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q  <= '0;
      cmd_attr_q  <= '0;
      tid_q       <= '0;
      cmd_q       <= '0;
      cp_q        <= 1'b0;
      dev_index_q <= '0;
      dtt_q       <= '0;
      mode_q      <= '0;
      rnw_q       <= 1'b0;
      wroc_q      <= 1'b0;
      toc_q       <= 1'b0;
      dbp_q       <= 1'b0;
      sre_q       <= 1'b0;
      data_len_q  <= '0;
    end else begin
      data_out_q  <= data_out_d;
      cmd_attr_q  <= cmd_attr_d;
      tid_q       <= tid_d;
      cmd_q       <= cmd_d;
      cp_q        <= cp_d;
      dev_index_q <= dev_index_d;
      dtt_q       <= dtt_d;
      mode_q      <= mode_d;
      rnw_q       <= rnw_d;
      wroc_q      <= wroc_d;
      toc_q       <= toc_d;
      dbp_q       <= dbp_d;
      sre_q       <= sre_d;
      data_len_q  <= data_len_d;
    end
  end

  assign data_out          = data_out_q;
  assign o_cccnt_CMD_ATTR  = cmd_attr_q;
  assign o_engine_TID      = tid_q;
  assign o_ccc_CMD         = cmd_q;
  assign o_engine_CP       = cp_q;
  assign o_cccnt_DEV_INDEX = dev_index_q;
  assign o_frmcnt_DTT      = dtt_q;
  assign o_engine_MODE     = mode_q;
  assign o_cccnt_RnW       = rnw_q;
  assign o_cccnt_WROC      = wroc_q;
  assign o_cccnt_TOC       = toc_q;
  assign o_cccnt_DBP       = dbp_q;
  assign o_cccnt_SRE       = sre_q;
  assign o_frmcnt_data_len = data_len_q;

endmodule

// File: tb/tb_internal_regfile.sv
// Self-checking bench for internal_regfile: directed scenarios plus randomized
// traffic against a byte-array / 64-bit descriptor reference model.
module tb_internal_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, rd_en, conf;
  logic [4:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [2:0]  cmd_attr;
  logic [3:0]  tid;
  logic [7:0]  cmd;
  logic        cp;
  logic [4:0]  dev_index;
  logic [2:0]  dtt;
  logic [2:0]  mode;
  logic        rnw, wroc, toc, dbp, sre;
  logic [15:0] data_len;

  internal_regfile dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .data_in(data_in), .data_out(data_out), .i_engine_Dummy_conf(conf),
    .o_cccnt_CMD_ATTR(cmd_attr), .o_engine_TID(tid), .o_ccc_CMD(cmd),
    .o_engine_CP(cp), .o_cccnt_DEV_INDEX(dev_index), .o_frmcnt_DTT(dtt),
    .o_engine_MODE(mode), .o_cccnt_RnW(rnw), .o_cccnt_WROC(wroc),
    .o_cccnt_TOC(toc), .o_cccnt_DBP(dbp), .o_cccnt_SRE(sre),
    .o_frmcnt_data_len(data_len)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model state
  logic [7:0]  mem [32];
  logic [7:0]  exp_dout;
  logic [47:0] exp_outs;

`ifdef INTERNAL_REGF_WR_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_desc();
    logic [63:0] d = '0;
    for (int b = 1; b <= 8; b++) d = d | (64'(mem[b]) << (8 * (b - 1)));
    return d;
  endfunction

  // Field layout of the descriptor, packed in output-port order
  function automatic logic [47:0] decode(input logic [63:0] d);
    return {d[2:0], d[6:3], d[14:7], d[15], d[20:16], d[25:23], d[28:26],
            d[29], d[30], d[31], d[32], d[33], d[63:48]};
  endfunction

  function automatic logic [47:0] dut_outs();
    return {cmd_attr, tid, cmd, cp, dev_index, dtt, mode,
            rnw, wroc, toc, dbp, sre, data_len};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    exp_dout = 8'h00;
    exp_outs = '0;
  endtask

  task automatic cyc(input logic w, input logic r, input logic c,
                     input logic [4:0] a, input logic [7:0] d, input string tag);
    @(negedge clk);
    wr_en = w; rd_en = r; conf = c; addr = a; data_in = d;
    @(posedge clk);
    if (r) exp_dout = (Bypass && w) ? d : mem[a];
    if (c) exp_outs = decode(model_desc());
    if (w) mem[a] = d;
    #1;
    check({tag, ".dout"}, 64'(data_out), 64'(exp_dout));
    check({tag, ".desc"}, 64'(dut_outs()), 64'(exp_outs));
  endtask

  task automatic idle();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; conf = 1'b0;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; conf = 1'b0; addr = '0; data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.dout", 64'(data_out), 64'h0);
    check("reset.desc", 64'(dut_outs()), 64'h0);
    @(negedge clk); reset = 1'b1;

    cyc(0, 1, 0, 5'd0,  8'h00, "rd0_reset");
    cyc(0, 1, 0, 5'd1,  8'h00, "rd1_reset");
    cyc(0, 1, 0, 5'd31, 8'h00, "rd31_reset");

    // Byte access at the address extremes
    cyc(1, 0, 0, 5'd0,  8'hAA, "wr0");
    cyc(1, 0, 0, 5'd1,  8'hBB, "wr1");
    cyc(1, 0, 0, 5'd31, 8'hCC, "wr31");
    cyc(0, 1, 0, 5'd0,  8'h00, "rd0");
    check("rd0.lit", 64'(data_out), 64'hAA);
    cyc(0, 1, 0, 5'd1,  8'h00, "rd1");
    check("rd1.lit", 64'(data_out), 64'hBB);
    cyc(0, 1, 0, 5'd31, 8'h00, "rd31");
    check("rd31.lit", 64'(data_out), 64'hCC);

    // Descriptor decode with known-good literal values
    begin
      logic [7:0] pat [8] = '{8'hA0, 8'hB1, 8'h01, 8'h15, 8'h7B, 8'hA0, 8'hC0, 8'hAC};
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 5'(i + 1), pat[i], "wr_desc");
    end
    cyc(0, 0, 1, 5'd0, 8'h00, "latch");
    check("dec.cmd_attr", 64'(cmd_attr), 64'd0);
    check("dec.tid", 64'(tid), 64'd4);
    check("dec.cmd", 64'(cmd), 64'h63);
    check("dec.cp", 64'(cp), 64'd1);
    check("dec.dev_index", 64'(dev_index), 64'd1);
    check("dec.dtt", 64'(dtt), 64'd2);
    check("dec.mode", 64'(mode), 64'd5);
    check("dec.flags", 64'({rnw, wroc, toc, dbp, sre}), 64'b00011);
    check("dec.data_len", 64'(data_len), 64'hACC0);

    // Hold while latch enable is low, then relatch
    cyc(1, 0, 0, 5'd1, 8'hFF, "hold_wr");
    cyc(0, 0, 0, 5'd0, 8'h00, "hold");
    check("hold.tid", 64'(tid), 64'd4);
    cyc(0, 0, 1, 5'd0, 8'h00, "relatch");
    check("relatch.cmd_attr", 64'(cmd_attr), 64'd7);
    check("relatch.tid", 64'(tid), 64'hF);
    check("relatch.cmd", 64'(cmd), 64'h63);

    // Latch coincident with write uses pre-write contents
    cyc(1, 0, 1, 5'd8, 8'h12, "latch_wr");
    check("latch_wr.len", 64'(data_len), 64'hACC0);
    cyc(0, 0, 1, 5'd0, 8'h00, "latch_after");
    check("latch_after.len", 64'(data_len), 64'h12C0);

    // Same-address read and write
    cyc(1, 0, 0, 5'd5, 8'h11, "rw_pre");
    cyc(1, 1, 0, 5'd5, 8'h22, "rw_same");
    check("rw_same.lit", 64'(data_out), Bypass ? 64'h22 : 64'h11);
    cyc(0, 1, 0, 5'd5, 8'h00, "rw_after");
    check("rw_after.lit", 64'(data_out), 64'h22);

    // Randomized traffic, addresses biased toward the descriptor bytes
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 9)) : 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), a, 8'($urandom), "rand");
    end

    // Asynchronous reset between edges while the latch enable is held high
    cyc(0, 0, 1, 5'd0, 8'h00, "pre_rst");
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst.dout", 64'(data_out), 64'h0);
    check("async_rst.desc", 64'(dut_outs()), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    cyc(0, 1, 1, 5'd1, 8'h00, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
